procesador_fifo_salida: RTL and testbench
=========================================

PROCESADOR_FIFO_SALIDA -- requirements
Module: procesador_fifo_salida

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports `clock` and `reset`.
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and set the word width of the FIFO and the Avalon-ST source.
REQ-003 Parameter DEPTH SHALL default to 128 and set the total word capacity; it SHALL be a power of 2 and at least 4.
REQ-004 Ports SHALL be, in this order:
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `avalonmm_write_slave_address`  in  1  register select
- `avalonmm_write_slave_write`  in  1  write strobe
- `avalonmm_write_slave_writedata`  in  32  write data
- `avalonmm_write_slave_read`  in  1  read strobe
- `avalonmm_write_slave_readdata`  out  32  read data, read latency 1
- `avalonst_source_data`  out  DATA_WIDTH  head word
- `avalonst_source_valid`  out  1  head word valid
- `avalonst_source_ready`  in  1  sink ready, ready latency 0

Function
REQ-005 The block SHALL be an MM-to-ST FIFO: the processor pushes words over Avalon-MM and they leave over Avalon-ST in order.
REQ-006 A push SHALL be a write to address 0, storing writedata[DATA_WIDTH-1:0].
REQ-007 A pop SHALL occur in any cycle where `avalonst_source_valid` and `avalonst_source_ready` are both 1.
REQ-008 `level` SHALL count the words held (including the word presented on the source), range 0..DEPTH.
- `empty` SHALL be `level`==0.
- `full` SHALL be `level`==DEPTH.
REQ-009 A push SHALL be accepted when `level`<DEPTH, or when `level`==DEPTH and a pop occurs in the same cycle.
REQ-010 A push to a full FIFO with no pop in the same cycle SHALL be dropped and SHALL set the sticky `overflow` flag.
REQ-011 `level` SHALL update each cycle as +1 on an accepted push, -1 on a pop, and unchanged when both or neither occur.
REQ-012 Latency: a word pushed into an empty FIFO SHALL appear with `avalonst_source_valid`=1 in the next cycle.
REQ-013 `avalonst_source_valid` SHALL be 1 exactly when `level`>0.
REQ-014 `avalonst_source_data` SHALL hold the oldest word and SHALL stay stable while `avalonst_source_valid`=1 and `avalonst_source_ready`=0.
REQ-015 After a pop, the next word SHALL be presented in the following cycle with no bubble when `level`>1.
REQ-016 Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap modulo DEPTH without loss or duplication.
REQ-017 A write to address 1 SHALL act as a control write with these bit meanings:
- bit0=1 SHALL flush: `level`, pointers and `avalonst_source_valid` SHALL be 0 in the next cycle, overriding any pop in the same cycle.
- bit1=1 SHALL clear `overflow`.
REQ-018 Reads SHALL return the following data in the cycle after the read strobe:
- Address 0: `readdata` SHALL be {zeros, `level`} with `level` in bits [15:0].
- Address 1: `readdata` SHALL be {zeros, `overflow`, `full`, `empty`} in bits [2:0].
- The sampled values SHALL be those present in the strobe cycle.
REQ-019 When no read is strobed, `readdata` SHALL hold its last value.
REQ-020 If a push is dropped in the same cycle as an `overflow` clear, set SHALL win and `overflow` SHALL be 1.
REQ-021 Writedata bits above DATA_WIDTH and control bits [31:2] SHALL be ignored.

Reset
REQ-022 While `reset`=1 at a clock edge, the block SHALL set:
- `level`=0 and both pointers=0;
- `overflow`=0;
- `avalonst_source_valid`=0;
- `avalonst_source_data`=0;
- `avalonmm_write_slave_readdata`=0.
REQ-023 Reset mid-operation SHALL discard all stored words, and a push in the reset cycle SHALL be ignored.
REQ-024 Memory contents SHALL NOT require reset.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset, then push 0xA5A5_0001 with ready=0 -> next cycle valid=1 and data=0xA5A5_0001; read address 0 -> readdata=1.
- Push 128 words 0..127 with ready=0 -> addr1 readdata=0x2 (full); push 0xDEAD -> addr1 readdata=0x6; drain with ready=1 -> 0..127 in order over 128 consecutive cycles with valid=1, then valid=0.
- At full with ready=1, push 0x1234 -> no overflow, level stays 128, and 0x1234 emerges last.
- Push 200 words with ready toggling 1/0 per cycle, keeping level <128 -> output sequence identical to input, exercising pointer wrap.
- With 5 words queued and ready=1, write addr1=0x1 -> next cycle valid=0 and level=0; write addr1=0x2 after an overflow -> addr1 readdata bit2=0.
- Assert reset with 10 words queued and a simultaneous push -> next cycle valid=0, level=0, overflow=0.

Source files
------------

// File: rtl/procesador_fifo_salida.sv
// procesador_fifo_salida
//   MM-to-ST output FIFO. A processor pushes words over an Avalon-MM slave
//   and they leave, in order, through an Avalon-ST source (ready latency 0).
//
// Ports
//   clock, reset                    : sole clock, synchronous active-high reset
//   avalonmm_write_slave_address    : 0 = data push / level read,
//                                     1 = control write / status read
//   avalonmm_write_slave_write      : write strobe
//   avalonmm_write_slave_writedata  : push word (low DATA_WIDTH bits) or control
//                                     bits (bit0 flush, bit1 clear overflow)
//   avalonmm_write_slave_read       : read strobe
//   avalonmm_write_slave_readdata   : registered read data, latency 1
//   avalonst_source_data/valid      : head word and its valid
//   avalonst_source_ready           : sink ready
//
// DEPTH must be a power of two and at least 4; DATA_WIDTH must not exceed 32.

module procesador_fifo_salida #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  avalonmm_write_slave_address,
  input  logic                  avalonmm_write_slave_write,
  input  logic [31:0]           avalonmm_write_slave_writedata,
  input  logic                  avalonmm_write_slave_read,
  output logic [31:0]           avalonmm_write_slave_readdata,
  output logic [DATA_WIDTH-1:0] avalonst_source_data,
  output logic                  avalonst_source_valid,
  input  logic                  avalonst_source_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // Storage: plain array with a registered read port so it maps to block RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [AW:0]           level_reg, level_next;
  logic                  overflow_reg, overflow_next;
  logic [31:0]           readdata_reg, readdata_next;
  logic [DATA_WIDTH-1:0] data_reg;

  logic                  empty, full, pop;
  logic                  push_req, push_accept, push_drop;
  logic                  ctrl_wr, flush, overflow_clear;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] push_word;

  // Upper writedata bits and control bits [31:2] have no function.
  logic unused_writedata;
  assign unused_writedata = ^avalonmm_write_slave_writedata;

  assign push_word = avalonmm_write_slave_writedata[DATA_WIDTH-1:0];

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LEVEL_FULL);
  assign pop   = !empty && avalonst_source_ready;

  assign push_req       = avalonmm_write_slave_write && !avalonmm_write_slave_address;
  assign ctrl_wr        = avalonmm_write_slave_write &&  avalonmm_write_slave_address;
  assign flush          = ctrl_wr && avalonmm_write_slave_writedata[0];
  assign overflow_clear = ctrl_wr && avalonmm_write_slave_writedata[1];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_accept = push_req && (!full || pop);
  assign push_drop   = push_req && full && !pop;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;
    readdata_next = readdata_reg;

    if (flush) begin
      // Flush overrides a concurrent pop.
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push_accept) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (pop)         rd_ptr_next = rd_ptr_reg + PTR_ONE;
      case ({push_accept, pop})
        2'b10:   level_next = level_reg + LEVEL_ONE;
        2'b01:   level_next = level_reg - LEVEL_ONE;
        default: level_next = level_reg;
      endcase
    end

    // A dropped push takes priority over a clear in the same cycle.
    if (push_drop)           overflow_next = 1'b1;
    else if (overflow_clear) overflow_next = 1'b0;

    if (avalonmm_write_slave_read) begin
      if (avalonmm_write_slave_address)
        readdata_next = {29'd0, overflow_reg, full, empty};
      else
        readdata_next = 32'(level_reg);
    end
  end

  // The pushed word lands at the address the head will read next cycle only
  // when the FIFO is (or is becoming) empty; forward it past the RAM then.
  assign bypass = push_accept && (wr_ptr_reg == rd_ptr_next);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      readdata_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
      readdata_reg <= readdata_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push_accept && !reset)
      mem[wr_ptr_reg] <= push_word;
  end

  // Head register: registered RAM read at the next head address, so the
  // following word is presented the cycle after a pop without a bubble.
  always_ff @(posedge clock) begin
    if (reset)
      data_reg <= '0;
    else if (bypass)
      data_reg <= push_word;
    else
      data_reg <= mem[rd_ptr_next];
  end

  assign avalonst_source_valid         = !empty;
  assign avalonst_source_data          = data_reg;
  assign avalonmm_write_slave_readdata = readdata_reg;

endmodule

// File: tb/tb_procesador_fifo_salida.sv
// Self-checking bench for procesador_fifo_salida. The reference model is a
// word queue plus an overflow bit, updated at each clock edge from the inputs
// present at that edge.

module tb_procesador_fifo_salida;

  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          addr  = 1'b0;
  logic          wr    = 1'b0;
  logic          rd    = 1'b0;
  logic          ready = 1'b0;
  logic [31:0]   wd    = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] data;
  logic          valid;

  always #5 clock = ~clock;

  procesador_fifo_salida #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .avalonmm_write_slave_address   (addr),
    .avalonmm_write_slave_write     (wr),
    .avalonmm_write_slave_writedata (wd),
    .avalonmm_write_slave_read      (rd),
    .avalonmm_write_slave_readdata  (readdata),
    .avalonst_source_data           (data),
    .avalonst_source_valid          (valid),
    .avalonst_source_ready          (ready)
  );

  logic [DW-1:0] q[$];
  logic          m_ovf   = 1'b0;
  logic [31:0]   m_rdata = '0;
  int            n_cmp   = 0;
  int            n_err   = 0;

  task automatic set_in(input logic w, input logic a, input logic [31:0] d,
                        input logic r, input logic rdy);
    wr = w; addr = a; wd = d; rd = r; ready = rdy;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge,
  // and return 1 time unit later so DUT outputs are settled.
  task automatic tick();
    bit pop;
    @(posedge clock);
    if (reset) begin
      q.delete();
      m_ovf   = 1'b0;
      m_rdata = '0;
    end else begin
      pop = (q.size() > 0) && ready;
      if (rd)
        m_rdata = addr ? {29'd0, m_ovf, (q.size() == DEPTH), (q.size() == 0)}
                       : 32'(q.size());
      if (wr && addr) begin
        if (wd[0]) q.delete();
        else if (pop) void'(q.pop_front());
        if (wd[1]) m_ovf = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (wr) begin
          if (q.size() < DEPTH) q.push_back(wd[DW-1:0]);
          else m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b1, 1'b0, 32'h55, 1'b1, 1'b1);
    tick(); tick();
    reset = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    n_cmp++; if (data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", data); end
    n_cmp++; if (readdata !== '0) begin n_err++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
    $display("test_reset done");
  endtask

  task automatic test_first_push();
    set_in(1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL first_valid got=%0b exp=1", valid); end
    n_cmp++; if (data !== 32'hA5A5_0001) begin n_err++; $display("FAIL first_data got=%h exp=a5a50001", data); end
    tick();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (readdata !== 32'd1) begin n_err++; $display("FAIL first_level got=%0d exp=1", readdata); end
    $display("test_first_push done");
  endtask

  task automatic test_full_overflow();
    set_in(1'b1, 1'b1, 32'h1, 1'b0, 1'b0); tick();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, 32'(i), 1'b0, 1'b0); tick();
    end
    set_in(1'b0, 1'b1, '0, 1'b1, 1'b0); tick();
    n_cmp++; if (readdata !== 32'h2) begin n_err++; $display("FAIL full_status got=%h exp=2", readdata); end
    set_in(1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, '0, 1'b1, 1'b0); tick();
    n_cmp++; if (readdata !== 32'h6) begin n_err++; $display("FAIL ovf_status got=%h exp=6", readdata); end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (valid !== 1'b1 || data !== DW'(i)) begin
        n_err++; $display("FAIL drain[%0d] valid=%0b data=%h exp valid=1 data=%h", i, valid, data, i);
      end
      tick();
    end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL drained_valid got=%0b exp=0", valid); end
    $display("test_full_overflow done");
  endtask

  task automatic test_full_pop_push();
    set_in(1'b1, 1'b1, 32'h2, 1'b0, 1'b0); tick();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, $urandom, 1'b0, 1'b0); tick();
    end
    set_in(1'b1, 1'b0, 32'h1234, 1'b0, 1'b1); tick();
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0); tick();
    n_cmp++; if (readdata !== 32'd128) begin n_err++; $display("FAIL fullpp_level got=%0d exp=128", readdata); end
    set_in(1'b0, 1'b1, '0, 1'b1, 1'b0); tick();
    n_cmp++; if (readdata !== 32'h2) begin n_err++; $display("FAIL fullpp_status got=%h exp=2", readdata); end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (valid !== 1'b1 || q.size() == 0 || data !== q[0]) begin
        n_err++; $display("FAIL fullpp_drain[%0d] valid=%0b data=%h exp=%h", i, valid, data, (q.size() > 0) ? q[0] : 'x);
      end
      if (i == DEPTH - 1) begin
        n_cmp++; if (data !== 32'h1234) begin n_err++; $display("FAIL fullpp_last got=%h exp=1234", data); end
      end
      tick();
    end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL fullpp_empty got=%0b exp=0", valid); end
    $display("test_full_pop_push done");
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 200; c++) begin
      set_in(1'b1, 1'b0, $urandom, 1'b0, c[0]);
      n_cmp++;
      if (valid !== (q.size() > 0) || (q.size() > 0 && data !== q[0])) begin
        n_err++; $display("FAIL wrap[%0d] valid=%0b data=%h exp level=%0d", c, valid, data, q.size());
      end
      tick();
    end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < DEPTH && q.size() > 0; c++) begin
      n_cmp++;
      if (valid !== 1'b1 || data !== q[0]) begin
        n_err++; $display("FAIL wrap_drain[%0d] valid=%0b data=%h exp=%h", c, valid, data, q[0]);
      end
      tick();
    end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got=%0b exp=0", valid); end
    $display("test_wrap done");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, $urandom, 1'b0, 1'b0); tick();
    end
    set_in(1'b1, 1'b1, 32'h1, 1'b0, 1'b1); tick();
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%0b exp=0", valid); end
    tick();
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL flush_level got=%0d exp=0", readdata); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_in(1'b1, 1'b0, $urandom, 1'b0, 1'b0); tick();
    end
    set_in(1'b0, 1'b1, '0, 1'b1, 1'b0); tick();
    n_cmp++; if (readdata !== 32'h6) begin n_err++; $display("FAIL flush_ovf got=%h exp=6", readdata); end
    set_in(1'b1, 1'b1, 32'hFFFF_FFF2, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, '0, 1'b1, 1'b0); tick();
    n_cmp++; if (readdata !== 32'h2) begin n_err++; $display("FAIL ovf_clear got=%h exp=2", readdata); end
    set_in(1'b1, 1'b1, 32'h1, 1'b0, 1'b0); tick();
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_in(1'b1, 1'b0, $urandom, 1'b0, 1'b0); tick();
    end
    set_in(1'b1, 1'b1, 32'h1, 1'b0, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b0, $urandom, 1'b0, 1'b0); tick();
    end
    reset = 1'b1;
    set_in(1'b1, 1'b0, 32'h77, 1'b0, 1'b0); tick();
    reset = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%0b exp=0", valid); end
    tick();
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL rstmid_level got=%0d exp=0", readdata); end
    set_in(1'b0, 1'b1, '0, 1'b1, 1'b0); tick();
    n_cmp++; if (readdata !== 32'h1) begin n_err++; $display("FAIL rstmid_status got=%h exp=1", readdata); end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int rdy_pct;
    for (int c = 0; c < 4000; c++) begin
      rdy_pct = ((c / 400) % 2 == 0) ? 20 : 85;
      reset = ($urandom_range(999) == 0);
      set_in($urandom_range(99) < 60,
             $urandom_range(127) == 0,
             $urandom,
             $urandom_range(3) == 0,
             $urandom_range(99) < rdy_pct);
      if (!wr && rd) addr = $urandom_range(1);
      tick();
      n_cmp++;
      if (valid !== (q.size() > 0) || (q.size() > 0 && data !== q[0])) begin
        n_err++; $display("FAIL rand_out[%0d] valid=%0b data=%h exp level=%0d head=%h", c, valid, data, q.size(), (q.size() > 0) ? q[0] : 'x);
      end
      n_cmp++;
      if (readdata !== m_rdata) begin
        n_err++; $display("FAIL rand_readdata[%0d] got=%h exp=%h", c, readdata, m_rdata);
      end
    end
    reset = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_full_overflow();
    test_full_pop_push();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
